// File: rtl/counter_vector_checker.sv
// On-hardware self-test for an up/down accumulating counter: holds the target in
// reset, streams LFSR or ramp vectors, tracks a golden count and latches the first mismatch.
module counter_vector_checker #(
  parameter int          WIDTH        = 8,
  parameter int          NUM_VECTORS  = 1024,
  parameter int          RESET_CYCLES = 60,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             lfsr_en,
  input  logic [WIDTH-1:0] count,
  output logic             dut_reset,
  output logic             upDown,
  output logic [WIDTH-1:0] addVal,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [15:0]      err_cycle,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_actual
);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_FLUSH, S_DONE} state_t;

  typedef struct packed {
    logic             ud;
    logic [WIDTH-1:0] av;
  } vec_t;

  state_t           state, nxt;
  logic             start_q, lfsr_en_q, mode;
  logic [15:0]      lfsr, vidx;
  logic [31:0]      rcnt;
  logic [WIDTH-1:0] model;
  logic             chk_en, mismatch, last_vec, last_rst;
  vec_t             vec;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    lfsr_step = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign chk_en   = (state == S_RUN) || (state == S_FLUSH);
  assign mismatch = chk_en && (count != model);
  assign last_vec = (vidx == 16'(NUM_VECTORS - 1));
  assign last_rst = (rcnt == 32'(RESET_CYCLES - 1));

  // next vector to drive, taken from the current LFSR state or the unit ramp
  always_comb begin
    vec.ud = 1'b0;
    vec.av = WIDTH'(1);
    if (mode) begin
      vec.ud = lfsr[15];
      vec.av = WIDTH'(lfsr);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_q) nxt = S_RESET;
      S_RESET:        if (last_rst) nxt = S_RUN;
      S_RUN:          if (mismatch) nxt = S_DONE;
                      else if (last_vec) nxt = S_FLUSH;
      S_FLUSH:        nxt = S_DONE;
      default:        nxt = S_IDLE;
    endcase
  end

  // start/lfsr_en are registered first, so the FSM acts one edge after sampling
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      lfsr_en_q    <= 1'b0;
      mode         <= 1'b0;
      lfsr         <= SEED;
      vidx         <= '0;
      rcnt         <= '0;
      model        <= '0;
      dut_reset    <= 1'b1;
      upDown       <= 1'b0;
      addVal       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      err_cycle    <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      state     <= nxt;
      start_q   <= start;
      lfsr_en_q <= lfsr_en;
      busy      <= (nxt == S_RESET) || (nxt == S_RUN) || (nxt == S_FLUSH);
      dut_reset <= !((nxt == S_RUN) || (nxt == S_FLUSH));
      done      <= (nxt == S_DONE);
      upDown    <= 1'b0;
      addVal    <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (nxt == S_RESET) begin
            pass         <= 1'b0;
            fail         <= 1'b0;
            err_cycle    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            lfsr         <= SEED;
            model        <= '0;
            vidx         <= '0;
            rcnt         <= '0;
            mode         <= lfsr_en_q;
          end
        end
        S_RESET: begin
          rcnt <= rcnt + 32'd1;
          if (nxt == S_RUN) begin
            upDown <= vec.ud;
            addVal <= vec.av;
            lfsr   <= lfsr_step(lfsr);
          end
        end
        S_RUN: begin
          if (mismatch) begin
            fail         <= 1'b1;
            err_cycle    <= vidx;
            err_expected <= model;
            err_actual   <= count;
          end else begin
            model <= upDown ? model - addVal : model + addVal;
            vidx  <= vidx + 16'd1;
            if (nxt == S_RUN) begin
              upDown <= vec.ud;
              addVal <= vec.av;
              lfsr   <= lfsr_step(lfsr);
            end
          end
        end
        S_FLUSH: begin
          if (mismatch) begin
            fail         <= 1'b1;
            err_cycle    <= vidx;
            err_expected <= model;
            err_actual   <= count;
          end else begin
            pass <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_vector_checker.sv
// Directed bench: two checker instances (ramp N=300, LFSR N=1024) each driving a
// behavioural target counter with injectable faults.
module tb_counter_vector_checker;
  localparam int R  = 60;
  localparam int NA = 300;
  localparam int NB = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_a, lfsr_en_a, dut_reset_a, ud_a, busy_a, done_a, pass_a, fail_a;
  logic [7:0] count_a, av_a, ee_a, ea_a, cnt_a;
  logic [15:0] ec_a;
  logic       start_b, lfsr_en_b, dut_reset_b, ud_b, busy_b, done_b, pass_b, fail_b;
  logic [7:0] count_b, av_b, ee_b, ea_b, cnt_b;
  logic [15:0] ec_b;
  logic       stuck_a, inv_b;

  int checks = 0;
  int errors = 0;

  counter_vector_checker #(.WIDTH(8), .NUM_VECTORS(NA), .RESET_CYCLES(R), .SEED(16'hACE1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .lfsr_en(lfsr_en_a), .count(count_a),
    .dut_reset(dut_reset_a), .upDown(ud_a), .addVal(av_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail(fail_a), .err_cycle(ec_a), .err_expected(ee_a), .err_actual(ea_a));

  counter_vector_checker #(.WIDTH(8), .NUM_VECTORS(NB), .RESET_CYCLES(R), .SEED(16'hACE1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .lfsr_en(lfsr_en_b), .count(count_b),
    .dut_reset(dut_reset_b), .upDown(ud_b), .addVal(av_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail(fail_b), .err_cycle(ec_b), .err_expected(ee_b), .err_actual(ea_b));

  // target counters: A can stick at zero, B can ignore the subtract direction
  always @(posedge clk) begin
    if (dut_reset_a) cnt_a <= 8'd0;
    else             cnt_a <= ud_a ? cnt_a - av_a : cnt_a + av_a;
  end
  assign count_a = stuck_a ? 8'd0 : cnt_a;

  always @(posedge clk) begin
    if (dut_reset_b)          cnt_b <= 8'd0;
    else if (ud_b && !inv_b)  cnt_b <= cnt_b - av_b;
    else                      cnt_b <= cnt_b + av_b;
  end
  assign count_b = cnt_b;

  function automatic logic [15:0] step(input logic [15:0] l);
    logic [15:0] s;
    s = l >> 1;
    if (l[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pulse start_a, return edges from the sampling edge to done; optional start pulse mid-run
  task automatic run_a(input bit mid_start, output int n, output logic [8:0] snap);
    n = 0;
    snap = '0;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (mid_start && n == 200) start_a = 1'b1;
      if (mid_start && n == 201) start_a = 1'b0;
      if (n == 100 + R) snap = {ud_a, av_a};
      if (done_a) break;
    end
  endtask

  // same for B, checking the stimulus stream against a fresh LFSR model each RUN cycle
  task automatic run_b(output int n);
    logic [15:0] l;
    l = 16'hACE1;
    n = 0;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (done_b) break;
      if (n >= R + 1 && n <= R + NB) begin
        chk("lfsr_ud", ud_b, l[15]);
        chk("lfsr_av", av_b, l[7:0]);
        l = step(l);
      end
    end
  endtask

  int n;
  logic [8:0] snap;
  int exp_i;
  logic [7:0] g, v, exp_e, exp_a;
  logic [15:0] lm;

  initial begin
    reset = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    lfsr_en_a = 1'b0; lfsr_en_b = 1'b1;
    stuck_a = 1'b0; inv_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {dut_reset_a, busy_a, done_a, pass_a, fail_a, ud_a}, 6'b100000);
    chk("rst_addval", av_a, 8'd0);
    chk("rst_err", {ec_a, ee_a, ea_a}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_after_rst", {busy_a, done_b, busy_b, dut_reset_a}, 4'b0001);

    // ramp, good target: 300 vectors wrap the model to 44
    run_a(1'b0, n, snap);
    chk("ramp_done_time", n, R + NA + 2);
    chk("ramp_pass", {pass_a, fail_a, busy_a}, 3'b100);
    chk("ramp_vec", snap, {1'b0, 8'd1});
    chk("ramp_final_count", count_a, 8'd44);
    chk("ramp_err_clear", {ec_a, ee_a, ea_a}, 32'd0);
    chk("ramp_stim_idle", {ud_a, av_a}, 9'd0);

    // start pulsed during RUN is ignored
    run_a(1'b1, n, snap);
    chk("midstart_done_time", n, R + NA + 2);
    chk("midstart_pass", {pass_a, fail_a}, 2'b10);

    // ramp, target stuck at zero: first miscompare at vector 1
    stuck_a = 1'b1;
    run_a(1'b0, n, snap);
    chk("stuck_done_time", n, R + 3);
    chk("stuck_flags", {done_a, fail_a, pass_a, busy_a}, 4'b1100);
    chk("stuck_err_cycle", ec_a, 16'd1);
    chk("stuck_err_exp", ee_a, 8'd1);
    chk("stuck_err_act", ea_a, 8'd0);
    stuck_a = 1'b0;

    // LFSR, good target, twice from DONE
    run_b(n);
    chk("lfsr_done_time", n, R + NB + 2);
    chk("lfsr_pass", {pass_b, fail_b}, 2'b10);
    run_b(n);
    chk("lfsr2_done_time", n, R + NB + 2);
    chk("lfsr2_pass", {pass_b, fail_b}, 2'b10);

    // LFSR, direction-inverted target; expectation from a good and a faulty model
    lm = 16'hACE1; g = 8'd0; v = 8'd0; exp_i = -1; exp_e = 8'd0; exp_a = 8'd0;
    for (int i = 0; i <= NB; i++) begin
      if (g != v) begin
        exp_i = i; exp_e = g; exp_a = v;
        break;
      end
      if (i == NB) break;
      g = lm[15] ? g - lm[7:0] : g + lm[7:0];
      v = v + lm[7:0];
      lm = step(lm);
    end
    inv_b = 1'b1;
    run_b(n);
    chk("inv_done_time", n, R + exp_i + 2);
    chk("inv_flags", {done_b, fail_b, pass_b}, 3'b110);
    chk("inv_err_cycle", ec_b, exp_i);
    chk("inv_err_exp", ee_b, exp_e);
    chk("inv_err_act", ea_b, exp_a);
    inv_b = 1'b0;

    // reset asserted during RUN vector 100 aborts asynchronously
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (R + 1 + 100) @(posedge clk);
    #2;
    chk("pre_abort", {busy_a, dut_reset_a, av_a}, {1'b1, 1'b0, 8'd1});
    reset = 1'b0;
    #1;
    chk("abort_flags", {dut_reset_a, busy_a, done_a, pass_a, fail_a, ud_a}, 6'b100000);
    chk("abort_addval", av_a, 8'd0);
    chk("abort_err", {ec_a, ee_a, ea_a}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_stays_idle", {busy_a, done_a, pass_a, dut_reset_a}, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_vector_checker.md
# counter_vector_checker

Synthesizable, on-FPGA self-test harness for an up/down accumulating counter (`upDown`, `addVal`, `count` contract). It holds the target in reset, drives a pseudo-random or ramp stimulus stream each cycle, tracks a golden model of the count, and compares the target's `count` output every cycle. It latches the first mismatch and reports pass or fail. It replaces simulation-only checking when the counter runs on hardware.

## Interface

Parameters:
- `WIDTH`, 8: counter and `addVal` width.
- `NUM_VECTORS`, 1024: stimulus vectors per run, range 1..65535.
- `RESET_CYCLES`, 60: cycles the target is held in reset before stimulus, range ≥1.
- `SEED`, 16'hACE1: LFSR seed, nonzero. Reloaded on every start.

Ports:
- `clk` input 1: sole clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: level, sampled in IDLE/DONE; begins a run.
- `lfsr_en` input 1: sampled at start. 1 selects LFSR stimulus; 0 selects ramp (upDown=0, addVal=1).
- `count` input WIDTH: target counter output.
- `dut_reset` output 1: active-high reset to the target.
- `upDown` output 1: stimulus direction. 0 adds, 1 subtracts.
- `addVal` output WIDTH: stimulus operand.
- `busy` output 1: run in progress (RESET/RUN/FLUSH).
- `done` output 1: run finished, held until next start.
- `pass` output 1: done with no mismatch.
- `fail` output 1: mismatch captured.
- `err_cycle` output 16: vector index at which the first mismatch was observed.
- `err_expected` output WIDTH: model value at the mismatch.
- `err_actual` output WIDTH: sampled `count` at the mismatch.

## Operation

- Target contract: `count` is a register. It resets to 0 while `dut_reset` is high; after that, `count_next = upDown ? count - addVal : count + addVal`, mod 2^WIDTH.
- The FSM has five states: IDLE, RESET, RUN, FLUSH, DONE.
  - IDLE: `start`=1 → RESET. Clears `fail`, `pass`, `done`, and `err_*`. Loads the LFSR with SEED, zeroes the model and vector index, latches `lfsr_en`.
  - RESET: `dut_reset`=1 for RESET_CYCLES cycles, then → RUN.
  - RUN: `dut_reset`=0. Vector i (i = 0..NUM_VECTORS-1) is driven on `upDown`/`addVal` for one cycle. Each cycle, `count` is compared to the model, which equals the result of vectors 0..i-1. The model then applies vector i. After the last vector → FLUSH.
  - FLUSH: one final compare (vector index = NUM_VECTORS), then → DONE.
  - DONE: `done`=1. `pass` = !`fail`. `start`=1 → RESET, with the same clearing as from IDLE.
- Mismatch (`count` != model in RUN or FLUSH):
  - Set `fail`.
  - Capture `err_cycle` = current vector index, `err_expected` = model, `err_actual` = `count`.
  - → DONE on the next edge. Only the first mismatch is captured.
- LFSR: 16-bit Galois, taps 16'hB400, shifts right once per RUN cycle. `addVal` = lfsr[WIDTH-1:0], `upDown` = lfsr[15].
- Model arithmetic is WIDTH bits and wraps silently. Underflow and overflow are not errors.
- `start` in RESET/RUN/FLUSH is ignored.

## Timing

- Reset values (async, while `reset`=0):
  - `dut_reset`=1.
  - `upDown`=0, `addVal`=0.
  - `busy`=0, `done`=0, `pass`=0, `fail`=0.
  - `err_*`=0.
  - State IDLE.
- Reset asserted mid-run aborts immediately to these values. No result is reported.
- All outputs are registered. `upDown`/`addVal` for vector i are valid for the whole of RUN cycle i.
- `start` sampled at edge E:
  - `busy`=1 from E+1.
  - `dut_reset` falls at E+1+RESET_CYCLES.
  - The first compare is in the cycle after E+1+RESET_CYCLES, against model 0.
  - `done`=1 at edge E+RESET_CYCLES+NUM_VECTORS+2 on a passing run.
- On a failing run, `done`/`fail` rise one edge after the mismatching compare cycle, and `busy` drops on the same edge.
- `upDown`/`addVal` return to 0 outside RUN.

## Test plan

- Ramp, good counter model, NUM_VECTORS=300:
  - `lfsr_en`=0, pulse `start`.
  - Required: `pass`=1, `fail`=0.
  - Final model = 300 mod 256 = 44, which checks wrap.
  - `done` rises exactly RESET_CYCLES+302 edges after start is sampled.
- Ramp, target `count` stuck at 0:
  - Required: `fail`=1, `err_cycle`=1, `err_expected`=1, `err_actual`=0.
  - `done` rises two edges after the first RUN cycle begins.
- LFSR, good counter model, NUM_VECTORS=1024:
  - Required: `pass`=1.
  - `upDown`/`addVal` sequence matches a bench LFSR model seeded 16'hACE1.
  - A second `start` from DONE reproduces the identical sequence.
- LFSR, target with inverted direction (adds when `upDown`=1):
  - Required: `fail`=1 at the first vector index following the first `upDown`=1 vector with nonzero `addVal`.
  - `err_expected`/`err_actual` match the bench models.
- `start` pulsed during RUN:
  - Required: ignored; completion time and result are unchanged.
- `reset` asserted at RUN vector 100:
  - Required: all outputs return to their reset values asynchronously and `dut_reset`=1.
  - After release, the FSM stays IDLE until `start`.
